// File: rtl/fly_swarm_controller.sv
// fly_swarm_controller: owns the fly formation (positions + alive flags).
// Marches the formation once per frame, steps it down at the screen edges,
// and resolves player bullets by scanning one fly per cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   frame_tick, start          per-frame pulse, new-wave pulse
//   bullet_valid/x/y           bullet point to test (accepted only when !busy)
//   busy                       bullet would be dropped this cycle
//   fly_x_flat/fly_y_flat      fly i at bits [i*10 +: 10]
//   fly_alive                  alive flags
//   hit/hit_idx/miss           bullet scan result (hit_idx held until next hit)
//   wave_clear, invaded        end-of-wave pulses

// Per-fly move evaluation: edge flags, next position, invasion flag.
module fly_swarm_lane #(
  parameter int STEP_X   = 2,
  parameter int STEP_Y   = 16,
  parameter int MIN_X    = 0,
  parameter int MAX_X    = 608,
  parameter int BOTTOM_Y = 400
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       alive,
  input  logic       dir,
  input  logic       move_down,
  output logic       at_right,
  output logic       at_left,
  output logic       low,
  output logic [9:0] nx,
  output logic [9:0] ny
);
  logic [10:0] x11, ny11;

  // 11-bit operands so the edge compares never wrap; left edge never subtracts
  assign x11      = {1'b0, x};
  assign at_right = alive && (x11 + 11'(STEP_X) > 11'(MAX_X));
  assign at_left  = alive && (x11 < 11'(MIN_X + STEP_X));
  assign ny11     = {1'b0, y} + (move_down ? 11'(STEP_Y) : 11'd0);
  assign low      = alive && (ny11 >= 11'(BOTTOM_Y));
  assign nx       = move_down ? x : (dir ? x - 10'(STEP_X) : x + 10'(STEP_X));
  assign ny       = ny11[9:0];
endmodule

module fly_swarm_controller #(
  parameter int FLY_COUNT = 16,
  parameter int COLS      = 8,
  parameter int START_X   = 64,
  parameter int START_Y   = 40,
  parameter int SPACING_X = 48,
  parameter int SPACING_Y = 40,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 16,
  parameter int MIN_X     = 0,
  parameter int MAX_X     = 608,
  parameter int BOTTOM_Y  = 400
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic                         start,
  input  logic                         bullet_valid,
  input  logic [9:0]                   bullet_x,
  input  logic [9:0]                   bullet_y,
  output logic                         busy,
  output logic [10*FLY_COUNT-1:0]      fly_x_flat,
  output logic [10*FLY_COUNT-1:0]      fly_y_flat,
  output logic [FLY_COUNT-1:0]         fly_alive,
  output logic                         hit,
  output logic [$clog2(FLY_COUNT)-1:0] hit_idx,
  output logic                         miss,
  output logic                         wave_clear,
  output logic                         invaded
);
  localparam int IW = $clog2(FLY_COUNT);

  typedef enum logic [1:0] {IDLE, RUN, MOVE, SCAN} state_t;
  state_t state, state_n;

  logic [FLY_COUNT-1:0][9:0] fx, fy, nx, ny;
  logic [FLY_COUNT-1:0]      right_v, left_v, low_v, kill_mask, alive_after;
  logic                      dir, pend_move, pend_scan, move_down, invade;
  logic [9:0]                bx, by;
  logic [IW-1:0]             idx;
  logic [10:0]               cx, cy, bx11, by11;
  logic                      hit_now, last, scan_done;

  assign fly_x_flat = fx;
  assign fly_y_flat = fy;

  function automatic logic [9:0] start_x(input int i);
    return 10'(START_X + (i % COLS) * SPACING_X);
  endfunction
  function automatic logic [9:0] start_y(input int i);
    return 10'(START_Y + (i / COLS) * SPACING_Y);
  endfunction

  genvar g;
  generate
    for (g = 0; g < FLY_COUNT; g++) begin : g_lane
      fly_swarm_lane #(
        .STEP_X(STEP_X), .STEP_Y(STEP_Y), .MIN_X(MIN_X),
        .MAX_X(MAX_X), .BOTTOM_Y(BOTTOM_Y)
      ) u_lane (
        .x(fx[g]), .y(fy[g]), .alive(fly_alive[g]), .dir(dir),
        .move_down(move_down), .at_right(right_v[g]), .at_left(left_v[g]),
        .low(low_v[g]), .nx(nx[g]), .ny(ny[g])
      );
    end
  endgenerate

  assign move_down = dir ? |left_v : |right_v;
  assign invade    = |low_v;

  // Scan datapath: one fly per cycle, 32x32 hit box
  always_comb begin
    cx        = {1'b0, fx[idx]};
    cy        = {1'b0, fy[idx]};
    bx11      = {1'b0, bx};
    by11      = {1'b0, by};
    hit_now   = fly_alive[idx] && (bx11 >= cx) && (bx11 < cx + 11'd32)
                && (by11 >= cy) && (by11 < cy + 11'd32);
    last      = (idx == IW'(FLY_COUNT - 1));
    scan_done = hit_now || last;
    kill_mask = '0;
    kill_mask[idx] = hit_now;
    alive_after = fly_alive & ~kill_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) state_n = RUN;
    else begin
      case (state)
        IDLE: state_n = IDLE;
        RUN: begin
          if (frame_tick)        state_n = MOVE;
          else if (bullet_valid) state_n = SCAN;
        end
        MOVE: begin
          if (invade)         state_n = IDLE;
          else if (pend_scan) state_n = SCAN;
          else                state_n = RUN;
        end
        SCAN: begin
          // a tick landing on the exit cycle is honoured rather than lost
          if (scan_done) begin
            if (alive_after == '0)            state_n = IDLE;
            else if (pend_move || frame_tick) state_n = MOVE;
            else                              state_n = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx <= '0; fy <= '0; fly_alive <= '0;
      dir <= 1'b0; pend_move <= 1'b0; pend_scan <= 1'b0;
      bx <= '0; by <= '0; idx <= '0;
      busy <= 1'b0; hit <= 1'b0; hit_idx <= '0; miss <= 1'b0;
      wave_clear <= 1'b0; invaded <= 1'b0;
    end else begin
      hit <= 1'b0; miss <= 1'b0; wave_clear <= 1'b0; invaded <= 1'b0;
      busy <= (state_n != RUN);
      if (start) begin
        for (int i = 0; i < FLY_COUNT; i++) begin
          fx[i] <= start_x(i);
          fy[i] <= start_y(i);
        end
        fly_alive <= '1;
        dir <= 1'b0; pend_move <= 1'b0; pend_scan <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (bullet_valid) begin
              bx <= bullet_x; by <= bullet_y; idx <= '0;
              if (frame_tick) pend_scan <= 1'b1;
            end
          end
          MOVE: begin
            fx <= nx; fy <= ny;
            dir <= dir ^ move_down;
            pend_scan <= 1'b0;
            if (invade) begin
              invaded <= 1'b1;
              fly_alive <= '0;
            end
          end
          SCAN: begin
            if (frame_tick) pend_move <= 1'b1;
            if (hit_now) begin
              fly_alive <= alive_after;
              hit <= 1'b1;
              hit_idx <= idx;
              if (alive_after == '0) wave_clear <= 1'b1;
            end
            if (scan_done) begin
              miss <= !hit_now;
              pend_move <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fly_swarm_controller.sv
module tb_fly_swarm_controller;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        frame_tick = 1'b0, start = 1'b0, bullet_valid = 1'b0;
  logic [9:0]  bullet_x = '0, bullet_y = '0;
  logic        busy, hit, miss, wave_clear, invaded;
  logic [159:0] fly_x_flat, fly_y_flat;
  logic [15:0] fly_alive;
  logic [3:0]  hit_idx;

  fly_swarm_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
    .bullet_valid(bullet_valid), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .busy(busy), .fly_x_flat(fly_x_flat), .fly_y_flat(fly_y_flat),
    .fly_alive(fly_alive), .hit(hit), .hit_idx(hit_idx), .miss(miss),
    .wave_clear(wave_clear), .invaded(invaded)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [9:0] fx(input int i);
    return fly_x_flat[i*10 +: 10];
  endfunction
  function automatic logic [9:0] fy(input int i);
    return fly_y_flat[i*10 +: 10];
  endfunction

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask
  task automatic tick2();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
  endtask
  task automatic fire(input logic [9:0] x, input logic [9:0] y);
    bullet_x = x; bullet_y = y; bullet_valid = 1'b1; cyc(); bullet_valid = 1'b0;
  endtask

  typedef struct {
    logic [9:0] bx, by;
    logic       exp_hit;
    int         exp_idx;
    int         lat;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int early, seen;
    logic [15:0] exp_alive;

    vecs[0] = '{10'd120, 10'd90,  1'b1, 9,  11};
    vecs[1] = '{10'd64,  10'd40,  1'b1, 0,  2};
    vecs[2] = '{10'd95,  10'd71,  1'b1, 0,  2};
    vecs[3] = '{10'd96,  10'd40,  1'b0, 0,  17};
    vecs[4] = '{10'd431, 10'd111, 1'b1, 15, 17};
    vecs[5] = '{10'd432, 10'd111, 1'b0, 0,  17};
    vecs[6] = '{10'd0,   10'd0,   1'b0, 0,  17};
    vecs[7] = '{10'd63,  10'd40,  1'b0, 0,  17};
    vecs[8] = '{10'd64,  10'd39,  1'b0, 0,  17};
    vecs[9] = '{10'd160, 10'd80,  1'b1, 10, 12};

    // reset state
    #3 rst_n = 1'b0;
    cyc(2);
    chk("rst_busy", busy, 0);
    chk("rst_alive", fly_alive, 0);
    chk("rst_x", |fly_x_flat, 0);
    chk("rst_y", |fly_y_flat, 0);
    chk("rst_pulses", {hit, miss, wave_clear, invaded}, 0);
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", busy, 1);

    // wave load
    do_start();
    chk("start_x0", fx(0), 64);
    chk("start_y0", fy(0), 40);
    chk("start_x9", fx(9), 112);
    chk("start_y9", fy(9), 80);
    chk("start_alive", fly_alive, 16'hFFFF);
    chk("start_busy", busy, 0);

    // single-bullet vectors on a fresh formation
    for (int v = 0; v < 10; v++) begin
      do_start();
      fire(vecs[v].bx, vecs[v].by);
      chk($sformatf("v%0d_busy", v), busy, 1);
      cyc(vecs[v].lat - 1);
      chk($sformatf("v%0d_hit", v), hit, vecs[v].exp_hit);
      chk($sformatf("v%0d_miss", v), miss, !vecs[v].exp_hit);
      if (vecs[v].exp_hit) begin
        chk($sformatf("v%0d_idx", v), hit_idx, vecs[v].exp_idx);
        chk($sformatf("v%0d_alive", v), fly_alive[vecs[v].exp_idx], 0);
      end else
        chk($sformatf("v%0d_alive", v), fly_alive, 16'hFFFF);
    end

    // repeat the same bullet after a kill: scans to the end and misses
    do_start();
    fire(10'd120, 10'd90);
    cyc(10);
    chk("rep_hit", hit, 1);
    fire(10'd120, 10'd90);
    cyc(15);
    chk("rep_early_miss", miss, 0);
    cyc();
    chk("rep_miss", miss, 1);
    chk("rep_nohit", hit, 0);

    // frame tick latency
    do_start();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    chk("tick_c1_x0", fx(0), 64);
    cyc();
    chk("tick_c2_x0", fx(0), 66);
    chk("tick_c2_busy", busy, 0);

    // march to the right edge, step down, reverse
    do_start();
    repeat (104) tick2();
    chk("march_x7", fx(7), 608);
    chk("march_y7", fy(7), 40);
    tick2();
    chk("edge_x7", fx(7), 608);
    chk("edge_y7", fy(7), 56);
    chk("edge_y9", fy(9), 96);
    tick2();
    chk("rev_x7", fx(7), 606);
    chk("rev_x0", fx(0), 270);

    // tick and bullet together: move first, scan sees moved positions
    do_start();
    frame_tick = 1'b1;
    fire(10'd65, 10'd50);
    frame_tick = 1'b0;
    cyc();
    chk("both_x0", fx(0), 66);
    cyc(15);
    chk("both_c17_miss", miss, 0);
    cyc();
    chk("both_miss", miss, 1);
    chk("both_nohit", hit, 0);

    // two ticks during a scan collapse to one move after the result
    do_start();
    fire(10'd0, 10'd0);
    cyc(2);
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    cyc(11);
    chk("pend_miss", miss, 1);
    chk("pend_x0_c17", fx(0), 64);
    cyc();
    chk("pend_x0_c18", fx(0), 66);
    chk("pend_busy_c18", busy, 0);
    cyc(2);
    chk("pend_x0_c20", fx(0), 66);

    // kill every fly in order
    do_start();
    for (int k = 0; k < 16; k++) begin
      fire(10'(64 + (k % 8) * 48 + 1), 10'(40 + (k / 8) * 40 + 1));
      cyc(k + 1);
      exp_alive = 16'hFFFF << (k + 1);
      chk($sformatf("kill%0d_hit", k), hit, 1);
      chk($sformatf("kill%0d_idx", k), hit_idx, k);
      chk($sformatf("kill%0d_alive", k), fly_alive, exp_alive);
      chk($sformatf("kill%0d_clear", k), wave_clear, (k == 15) ? 1 : 0);
    end
    chk("clear_busy", busy, 1);
    cyc();
    chk("clear_pulse_gone", wave_clear, 0);
    chk("clear_busy2", busy, 1);

    // twenty descents reach the bottom
    do_start();
    early = 0;
    for (int t = 1; t <= 2708; t++) begin
      tick2();
      if (t < 2708 && invaded) early++;
    end
    chk("inv_early", early, 0);
    chk("inv_pulse", invaded, 1);
    chk("inv_alive", fly_alive, 0);
    chk("inv_y8", fy(8), 400);
    chk("inv_busy", busy, 1);
    tick2();
    chk("inv_idle_pulse", invaded, 0);
    chk("inv_idle_y8", fy(8), 400);

    // start during a scan abandons the bullet
    do_start();
    fire(10'd0, 10'd0);
    cyc(4);
    do_start();
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (hit || miss) seen++;
      cyc();
    end
    chk("abandon_noresult", seen, 0);
    chk("abandon_alive", fly_alive, 16'hFFFF);

    // async reset in the middle of a scan
    do_start();
    fire(10'd120, 10'd90);
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_alive", fly_alive, 0);
    chk("midrst_x", |fly_x_flat, 0);
    chk("midrst_y", |fly_y_flat, 0);
    cyc(2);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (hit || miss) seen++;
      cyc();
    end
    chk("midrst_noresult", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
